// File: rtl/tile_buf_pkg.sv
// Shared types and helpers for the rotating tile buffer.
// Holds the per-buffer state enum, the NBUF ceiling and an index-width helper.
package tile_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } buf_state_e;

    localparam int MAX_NBUF = 4;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pingpong_tile_buf_if.sv
// Producer fill stream plus consumer random-read port of the tile buffer.
// master = producer/consumer side, slave = the buffer itself.
interface pingpong_tile_buf_if
    import tile_buf_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 3136,
    parameter int NBUF   = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = clog2_min1(NBUF);

    logic              fill_valid;
    logic              fill_ready;
    logic [DATA_W-1:0] fill_data;
    logic              fill_last;
    logic              rd_buf_ready;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_release;
    logic [AW:0]       rd_len;
    logic              rd_oob;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;

    modport master (
        output fill_valid, fill_data, fill_last,
        output rd_en, rd_addr, rd_release,
        input  fill_ready, rd_buf_ready, rd_data,
        input  rd_valid, rd_len, rd_oob,
        input  wr_idx, rd_idx
    );

    modport slave (
        input  fill_valid, fill_data, fill_last,
        input  rd_en, rd_addr, rd_release,
        output fill_ready, rd_buf_ready, rd_data,
        output rd_valid, rd_len, rd_oob,
        output wr_idx, rd_idx
    );

endinterface

// File: rtl/tile_buf_mem.sv
// One tile buffer: DATA_W x DEPTH RAM, one write port, one registered read.
// Ports: clk, we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o.
module tile_buf_mem #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 3136,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_tile_buf.sv
// NBUF-way rotating tile buffer: producer fills one buffer while the
// consumer reads another. Ports: clk, rst, bus (slave modport); with
// PINGPONG_TILE_BUF_PERF_EN defined also perf_fill_stall/rd_starve/tiles.
module pingpong_tile_buf
    import tile_buf_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 3136,
    parameter int NBUF   = 2
) (
    input  logic clk,
    input  logic rst,
    pingpong_tile_buf_if.slave bus
`ifdef PINGPONG_TILE_BUF_PERF_EN
    ,
    output logic [31:0] perf_fill_stall,
    output logic [31:0] perf_rd_starve,
    output logic [31:0] perf_tiles
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = clog2_min1(NBUF);

    buf_state_e        st_q  [NBUF];
    buf_state_e        st_d  [NBUF];
    logic [AW:0]       len_q [NBUF];
    logic [AW:0]       len_d [NBUF];
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic [IW-1:0]     sel_q;
    logic              rd_valid_q, oob_hit_q, rd_oob_q;
    logic [DATA_W-1:0] hold_q, rd_data;
    logic [DATA_W-1:0] rdata [NBUF];

    logic        fill_ready, buf_ready;
    logic [AW:0] cur_len;
    logic        fill_acc, tile_done;
    logic        rd_acc, rd_out, rd_rel;

    function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] i);
        return (i == IW'(NBUF - 1)) ? '0 : i + IW'(1);
    endfunction

    // Handshake outputs depend on registered state only.
    always_comb begin
        fill_ready = (st_q[wr_idx_q] != FULL);
        buf_ready  = (st_q[rd_idx_q] == FULL);
        cur_len    = buf_ready ? len_q[rd_idx_q] : '0;
    end

    assign fill_acc  = bus.fill_valid & fill_ready;
    assign tile_done = fill_acc &
                       (bus.fill_last | (waddr_q == AW'(DEPTH - 1)));
    assign rd_acc    = bus.rd_en & buf_ready;
    assign rd_out    = ({1'b0, bus.rd_addr} >= cur_len);
    assign rd_rel    = bus.rd_release & buf_ready;

    // Fill and release never target the same buffer: one needs
    // non-FULL, the other FULL.
    always_comb begin
        waddr_d  = waddr_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        for (int i = 0; i < NBUF; i++) begin
            st_d[i]  = st_q[i];
            len_d[i] = len_q[i];
            if (fill_acc && wr_idx_q == IW'(i)) begin
                st_d[i] = tile_done ? FULL : FILLING;
                if (tile_done)
                    len_d[i] = {1'b0, waddr_q} + (AW+1)'(1);
            end
            if (rd_rel && rd_idx_q == IW'(i))
                st_d[i] = EMPTY;
        end
        if (fill_acc)
            waddr_d = tile_done ? '0 : waddr_q + AW'(1);
        if (tile_done) wr_idx_d = nxt_idx(wr_idx_q);
        if (rd_rel)    rd_idx_d = nxt_idx(rd_idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBUF; i++) st_q[i] <= EMPTY;
            waddr_q  <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            st_q     <= st_d;
            waddr_q  <= waddr_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
        len_q <= len_d;
    end

    // Read pipeline; out-of-range reads skip the RAM and return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            oob_hit_q  <= 1'b0;
            rd_oob_q   <= 1'b0;
            sel_q      <= '0;
            hold_q     <= '0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                sel_q     <= rd_idx_q;
                oob_hit_q <= rd_out;
            end
            if (rd_acc && rd_out) rd_oob_q <= 1'b1;
            hold_q <= rd_data;
        end
    end

    // Without a new read the last returned word is held.
    assign rd_data = !rd_valid_q ? hold_q :
                     oob_hit_q   ? '0     : rdata[sel_q];

    for (genvar g = 0; g < NBUF; g++) begin : g_mem
        tile_buf_mem #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_mem (
            .clk     (clk),
            .we_i    (fill_acc && wr_idx_q == IW'(g)),
            .waddr_i (waddr_q),
            .wdata_i (bus.fill_data),
            .re_i    (rd_acc && !rd_out && rd_idx_q == IW'(g)),
            .raddr_i (bus.rd_addr),
            .rdata_o (rdata[g])
        );
    end

    assign bus.fill_ready   = fill_ready;
    assign bus.rd_buf_ready = buf_ready;
    assign bus.rd_len       = cur_len;
    assign bus.rd_data      = rd_data;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_oob       = rd_oob_q;
    assign bus.wr_idx       = wr_idx_q;
    assign bus.rd_idx       = rd_idx_q;

`ifdef PINGPONG_TILE_BUF_PERF_EN
    logic [31:0] stall_q, starve_q, tiles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            starve_q <= '0;
            tiles_q  <= '0;
        end else begin
            if (bus.fill_valid && !fill_ready && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            if (bus.rd_en && !buf_ready && starve_q != '1)
                starve_q <= starve_q + 32'd1;
            if (tile_done && tiles_q != '1)
                tiles_q <= tiles_q + 32'd1;
        end
    end

    assign perf_fill_stall = stall_q;
    assign perf_rd_starve  = starve_q;
    assign perf_tiles      = tiles_q;
`endif

endmodule
